// File: rtl/gb_cpu_common_pkg.sv
// Shared register-file encodings and write-request payloads for the CPU datapath.
package gb_cpu_common_pkg;

  typedef enum logic [2:0] {
    REG_A, REG_F, REG_B, REG_C, REG_D, REG_E, REG_H, REG_L
  } regfile_r8_t;

  typedef enum logic [2:0] {
    REG_AF, REG_BC, REG_DE, REG_HL, REG_SP
  } regfile_r16_t;

  typedef struct packed {
    logic z;
    logic n;
    logic h;
    logic c;
  } alu_flags_t;

  typedef struct packed {
    regfile_r8_t req;
    logic [7:0]  data;
    alu_flags_t  flags;
    logic        skip_flags;
  } alu_wr_t;

  typedef struct packed {
    regfile_r8_t req;
    logic [7:0]  data;
  } bus_wr_t;

endpackage

// File: rtl/gb_cpu_regfile_wr_sched.sv
// Register-file write-port scheduler: passes non-overlapping writes through
// and replays footprint-conflicting lower-priority writes (IDU > ALU > BUS).
module gb_cpu_regfile_wr_sched
  import gb_cpu_common_pkg::*;
(
  input  logic         clk,
  input  logic         reset,
  input  regfile_r8_t  alu_req,
  input  logic [7:0]   alu_data,
  input  alu_flags_t   alu_flags,
  input  logic         alu_skip_flags,
  input  logic         alu_wren,
  input  regfile_r16_t idu_req,
  input  logic [15:0]  idu_data,
  input  logic         idu_wren,
  input  regfile_r8_t  data_bus_req,
  input  logic [7:0]   data_bus_data,
  input  logic         data_bus_wren,
  output regfile_r8_t  rf_alu_req,
  output logic [7:0]   rf_alu_data,
  output alu_flags_t   rf_alu_flags,
  output logic         rf_alu_skip_flags,
  output logic         rf_alu_wren,
  output regfile_r16_t rf_idu_req,
  output logic [15:0]  rf_idu_data,
  output logic         rf_idu_wren,
  output regfile_r8_t  rf_data_bus_req,
  output logic [7:0]   rf_data_bus_data,
  output logic         rf_data_bus_wren,
  output logic         stall,
  output logic         sched_err
);

  localparam int unsigned NREG = 8;

  typedef enum logic {ST_RUN, ST_DRAIN} state_t;

  state_t  state_q, state_d;
  alu_wr_t pend_alu_q, pend_alu_d;
  bus_wr_t pend_bus_q, pend_bus_d;
  logic    pend_alu_vld_q, pend_alu_vld_d;
  logic    pend_bus_vld_q, pend_bus_vld_d;
  logic    sched_err_q, sched_err_d;

  logic [NREG-1:0] idu_fp, alu_fp, bus_fp, pend_alu_fp, pend_bus_fp;

  // One-hot set of 8-bit registers touched by a single-register write.
  function automatic logic [NREG-1:0] fp_r8(input regfile_r8_t r);
    logic [NREG-1:0] m;
    m    = '0;
    m[r] = 1'b1;
    return m;
  endfunction

  function automatic logic [NREG-1:0] fp_alu(input regfile_r8_t r, input logic skip);
    return fp_r8(r) | (skip ? NREG'(0) : fp_r8(REG_F));
  endfunction

  // SP lives outside the 8-bit file, so it never overlaps anything.
  function automatic logic [NREG-1:0] fp_r16(input regfile_r16_t r);
    logic [NREG-1:0] m;
    case (r)
      REG_AF:  m = fp_r8(REG_A) | fp_r8(REG_F);
      REG_BC:  m = fp_r8(REG_B) | fp_r8(REG_C);
      REG_DE:  m = fp_r8(REG_D) | fp_r8(REG_E);
      REG_HL:  m = fp_r8(REG_H) | fp_r8(REG_L);
      default: m = '0;
    endcase
    return m;
  endfunction

  assign idu_fp      = idu_wren       ? fp_r16(idu_req) : '0;
  assign alu_fp      = alu_wren       ? fp_alu(alu_req, alu_skip_flags) : '0;
  assign bus_fp      = data_bus_wren  ? fp_r8(data_bus_req) : '0;
  assign pend_alu_fp = pend_alu_vld_q ? fp_alu(pend_alu_q.req, pend_alu_q.skip_flags) : '0;
  assign pend_bus_fp = pend_bus_vld_q ? fp_r8(pend_bus_q.req) : '0;

  always_comb begin
    state_d           = state_q;
    pend_alu_d        = pend_alu_q;
    pend_bus_d        = pend_bus_q;
    pend_alu_vld_d    = pend_alu_vld_q;
    pend_bus_vld_d    = pend_bus_vld_q;
    sched_err_d       = sched_err_q;
    rf_alu_req        = alu_req;
    rf_alu_data       = alu_data;
    rf_alu_flags      = alu_flags;
    rf_alu_skip_flags = alu_skip_flags;
    rf_alu_wren       = 1'b0;
    rf_idu_req        = idu_req;
    rf_idu_data       = idu_data;
    rf_idu_wren       = 1'b0;
    rf_data_bus_req   = data_bus_req;
    rf_data_bus_data  = data_bus_data;
    rf_data_bus_wren  = 1'b0;

    case (state_q)
      ST_RUN: begin
        rf_idu_wren = idu_wren;
        if (alu_wren) begin
          if (|(alu_fp & idu_fp)) begin
            pend_alu_vld_d = 1'b1;
            pend_alu_d     = '{req: alu_req, data: alu_data, flags: alu_flags,
                               skip_flags: alu_skip_flags};
          end else begin
            rf_alu_wren = 1'b1;
          end
        end
        // BUS yields to the ALU request whether it issued or was captured.
        if (data_bus_wren) begin
          if (|(bus_fp & (idu_fp | alu_fp))) begin
            pend_bus_vld_d = 1'b1;
            pend_bus_d     = '{req: data_bus_req, data: data_bus_data};
          end else begin
            rf_data_bus_wren = 1'b1;
          end
        end
        if (pend_alu_vld_d || pend_bus_vld_d) state_d = ST_DRAIN;
      end
      ST_DRAIN: begin
        sched_err_d = sched_err_q | alu_wren | idu_wren | data_bus_wren;
        if (pend_alu_vld_q) begin
          rf_alu_req        = pend_alu_q.req;
          rf_alu_data       = pend_alu_q.data;
          rf_alu_flags      = pend_alu_q.flags;
          rf_alu_skip_flags = pend_alu_q.skip_flags;
          rf_alu_wren       = 1'b1;
          pend_alu_vld_d    = 1'b0;
        end
        if (pend_bus_vld_q && !(|(pend_alu_fp & pend_bus_fp))) begin
          rf_data_bus_req  = pend_bus_q.req;
          rf_data_bus_data = pend_bus_q.data;
          rf_data_bus_wren = 1'b1;
          pend_bus_vld_d   = 1'b0;
        end
        if (!pend_alu_vld_d && !pend_bus_vld_d) state_d = ST_RUN;
      end
      default: state_d = ST_RUN;
    endcase

    // Nothing reaches the register file while reset is held.
    if (!reset) begin
      rf_alu_wren      = 1'b0;
      rf_idu_wren      = 1'b0;
      rf_data_bus_wren = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q        <= ST_RUN;
      pend_alu_q     <= '0;
      pend_bus_q     <= '0;
      pend_alu_vld_q <= 1'b0;
      pend_bus_vld_q <= 1'b0;
      sched_err_q    <= 1'b0;
    end else begin
      state_q        <= state_d;
      pend_alu_q     <= pend_alu_d;
      pend_bus_q     <= pend_bus_d;
      pend_alu_vld_q <= pend_alu_vld_d;
      pend_bus_vld_q <= pend_bus_vld_d;
      sched_err_q    <= sched_err_d;
    end
  end

  assign stall     = (state_q == ST_DRAIN);
  assign sched_err = sched_err_q;

endmodule

// File: tb/tb_gb_cpu_regfile_wr_sched.sv
// Scoreboard bench for the register-file write scheduler: directed vectors push
// expected (cycle, payload) per port; a negedge monitor pops and compares.
module tb_gb_cpu_regfile_wr_sched;
  import gb_cpu_common_pkg::*;

  logic         clk = 1'b0;
  logic         reset;
  regfile_r8_t  alu_req;
  logic [7:0]   alu_data;
  alu_flags_t   alu_flags;
  logic         alu_skip_flags, alu_wren;
  regfile_r16_t idu_req;
  logic [15:0]  idu_data;
  logic         idu_wren;
  regfile_r8_t  data_bus_req;
  logic [7:0]   data_bus_data;
  logic         data_bus_wren;
  regfile_r8_t  rf_alu_req;
  logic [7:0]   rf_alu_data;
  alu_flags_t   rf_alu_flags;
  logic         rf_alu_skip_flags, rf_alu_wren;
  regfile_r16_t rf_idu_req;
  logic [15:0]  rf_idu_data;
  logic         rf_idu_wren;
  regfile_r8_t  rf_data_bus_req;
  logic [7:0]   rf_data_bus_data;
  logic         rf_data_bus_wren;
  logic         stall, sched_err;

  gb_cpu_regfile_wr_sched dut (
    .clk(clk), .reset(reset),
    .alu_req(alu_req), .alu_data(alu_data), .alu_flags(alu_flags),
    .alu_skip_flags(alu_skip_flags), .alu_wren(alu_wren),
    .idu_req(idu_req), .idu_data(idu_data), .idu_wren(idu_wren),
    .data_bus_req(data_bus_req), .data_bus_data(data_bus_data), .data_bus_wren(data_bus_wren),
    .rf_alu_req(rf_alu_req), .rf_alu_data(rf_alu_data), .rf_alu_flags(rf_alu_flags),
    .rf_alu_skip_flags(rf_alu_skip_flags), .rf_alu_wren(rf_alu_wren),
    .rf_idu_req(rf_idu_req), .rf_idu_data(rf_idu_data), .rf_idu_wren(rf_idu_wren),
    .rf_data_bus_req(rf_data_bus_req), .rf_data_bus_data(rf_data_bus_data),
    .rf_data_bus_wren(rf_data_bus_wren),
    .stall(stall), .sched_err(sched_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          cyc;
    logic [2:0]  req;
    logic [15:0] data;
    logic [4:0]  ext;
  } exp_t;

  exp_t       q_alu[$], q_idu[$], q_bus[$];
  int         n_cmp = 0;
  int         n_bad = 0;
  int         cyc = 0;
  logic [7:0] rf_model [0:7];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  task automatic unexpected(input string nm, input logic [15:0] data);
    n_cmp++;
    n_bad++;
    $display("FAIL %s: write data=%h issued but none expected (cycle %0d)", nm, data, cyc);
  endtask

  // Monitor: every regfile write must match the oldest expectation for its port.
  always @(negedge clk) begin
    exp_t       e;
    logic [2:0] b;
    if (reset) begin
      if (rf_idu_wren) begin
        if (q_idu.size() == 0) unexpected("idu_unexpected", rf_idu_data);
        else begin
          e = q_idu.pop_front();
          chk("idu_cycle", 32'(cyc), 32'(e.cyc));
          chk("idu_write", {13'b0, 3'(rf_idu_req), rf_idu_data}, {13'b0, e.req, e.data});
        end
        b = 3'(rf_idu_req);
        if (b < 3'd4) begin
          rf_model[{b[1:0], 1'b0}] = rf_idu_data[15:8];
          rf_model[{b[1:0], 1'b1}] = rf_idu_data[7:0];
        end
      end
      if (rf_alu_wren) begin
        if (q_alu.size() == 0) unexpected("alu_unexpected", {8'h00, rf_alu_data});
        else begin
          e = q_alu.pop_front();
          chk("alu_cycle", 32'(cyc), 32'(e.cyc));
          chk("alu_write",
              {16'b0, 3'(rf_alu_req), rf_alu_data, 4'(rf_alu_flags), rf_alu_skip_flags},
              {16'b0, e.req, e.data[7:0], e.ext});
        end
        rf_model[3'(rf_alu_req)] = rf_alu_data;
      end
      if (rf_data_bus_wren) begin
        if (q_bus.size() == 0) unexpected("bus_unexpected", {8'h00, rf_data_bus_data});
        else begin
          e = q_bus.pop_front();
          chk("bus_cycle", 32'(cyc), 32'(e.cyc));
          chk("bus_write", {21'b0, 3'(rf_data_bus_req), rf_data_bus_data},
              {21'b0, e.req, e.data[7:0]});
        end
        rf_model[3'(rf_data_bus_req)] = rf_data_bus_data;
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clr();
    alu_wren      = 1'b0;
    idu_wren      = 1'b0;
    data_bus_wren = 1'b0;
  endtask

  // Drivers also record the expected write; c is the cycle it must appear on the port.
  task automatic do_idu(input regfile_r16_t r, input logic [15:0] d, input int c);
    exp_t e;
    idu_req = r; idu_data = d; idu_wren = 1'b1;
    e.cyc = c; e.req = 3'(r); e.data = d; e.ext = '0;
    q_idu.push_back(e);
  endtask

  task automatic do_alu(input regfile_r8_t r, input logic [7:0] d, input logic sk, input int c);
    exp_t e;
    alu_req = r; alu_data = d; alu_skip_flags = sk; alu_wren = 1'b1;
    e.cyc = c; e.req = 3'(r); e.data = {8'h00, d}; e.ext = {4'(alu_flags), sk};
    q_alu.push_back(e);
  endtask

  task automatic do_bus(input regfile_r8_t r, input logic [7:0] d, input int c);
    exp_t e;
    data_bus_req = r; data_bus_data = d; data_bus_wren = 1'b1;
    e.cyc = c; e.req = 3'(r); e.data = {8'h00, d}; e.ext = '0;
    q_bus.push_back(e);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      step();
      clr();
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int c;
    for (int i = 0; i < 8; i++) rf_model[i] = 8'h00;
    reset = 1'b0;
    alu_req = REG_A; alu_data = '0; alu_flags = 4'b1010; alu_skip_flags = 1'b1;
    idu_req = REG_AF; idu_data = '0;
    data_bus_req = REG_A; data_bus_data = '0;
    clr();
    step();
    chk("rst_stall", 32'(stall), 32'd0);
    chk("rst_sched_err", 32'(sched_err), 32'd0);
    chk("rst_wrens", 32'({rf_alu_wren, rf_idu_wren, rf_data_bus_wren}), 32'd0);
    step();
    #1 reset = 1'b1;
    idle(2);

    // No conflict: all three issue together.
    step(); c = cyc;
    do_idu(REG_BC, 16'h1234, c); do_alu(REG_A, 8'h55, 1'b1, c); do_bus(REG_L, 8'h99, c);
    chk("t1_stall_c0", 32'(stall), 32'd0);
    step(); clr();
    chk("t1_stall_c1", 32'(stall), 32'd0);
    idle(2);

    // IDU HL vs ALU H: ALU replays one cycle later.
    step(); c = cyc;
    do_idu(REG_HL, 16'hBEEF, c); do_alu(REG_H, 8'h01, 1'b1, c + 1);
    chk("t2_stall_c0", 32'(stall), 32'd0);
    step(); clr();
    chk("t2_stall_c1", 32'(stall), 32'd1);
    step();
    chk("t2_stall_c2", 32'(stall), 32'd0);
    idle(2);

    // IDU AF vs ALU B writing flags: conflict on F.
    step(); c = cyc;
    do_idu(REG_AF, 16'h4321, c); do_alu(REG_B, 8'h77, 1'b0, c + 1);
    step(); clr();
    chk("t3a_stall_c1", 32'(stall), 32'd1);
    idle(2);

    // Same without flags: no conflict.
    step(); c = cyc;
    do_idu(REG_AF, 16'h4321, c); do_alu(REG_B, 8'h78, 1'b1, c);
    step(); clr();
    chk("t3b_stall_c1", 32'(stall), 32'd0);
    idle(2);

    // Double deferral onto E; bus lands last.
    step(); c = cyc;
    do_idu(REG_DE, 16'hCAFE, c); do_alu(REG_E, 8'h10, 1'b1, c + 1); do_bus(REG_E, 8'h20, c + 2);
    chk("t4_stall_c0", 32'(stall), 32'd0);
    step(); clr();
    chk("t4_stall_c1", 32'(stall), 32'd1);
    step();
    chk("t4_stall_c2", 32'(stall), 32'd1);
    step();
    chk("t4_stall_c3", 32'(stall), 32'd0);
    idle(1);
    chk("t4_final_E", 32'(rf_model[3'(REG_E)]), 32'h20);
    chk("t4_final_D", 32'(rf_model[3'(REG_D)]), 32'hCA);

    // Both deferred but disjoint from each other: replay together, one stall cycle.
    step(); c = cyc;
    do_idu(REG_HL, 16'h0102, c); do_alu(REG_H, 8'hA1, 1'b1, c + 1); do_bus(REG_L, 8'hB2, c + 1);
    step(); clr();
    chk("t7_stall_c1", 32'(stall), 32'd1);
    step();
    chk("t7_stall_c2", 32'(stall), 32'd0);
    idle(2);

    // ALU vs BUS on A, no IDU: ALU issues, BUS replays.
    step(); c = cyc;
    do_alu(REG_A, 8'h3C, 1'b1, c); do_bus(REG_A, 8'h4D, c + 1);
    step(); clr();
    chk("t8_stall_c1", 32'(stall), 32'd1);
    idle(2);

    // BUS writes F while ALU updates flags.
    step(); c = cyc;
    do_alu(REG_B, 8'h5E, 1'b0, c); do_bus(REG_F, 8'hF0, c + 1);
    step(); clr();
    chk("t9_stall_c1", 32'(stall), 32'd1);
    idle(2);

    // Protocol violation: bus write during stall is dropped and flagged.
    step(); c = cyc;
    do_idu(REG_BC, 16'h1111, c); do_alu(REG_C, 8'h22, 1'b1, c + 1);
    step(); clr();
    data_bus_req = REG_L; data_bus_data = 8'h77; data_bus_wren = 1'b1;
    chk("t5_stall_c1", 32'(stall), 32'd1);
    chk("t5_err_c1", 32'(sched_err), 32'd0);
    step(); clr();
    chk("t5_stall_c2", 32'(stall), 32'd0);
    chk("t5_err_c2", 32'(sched_err), 32'd1);
    idle(3);
    chk("t5_err_held", 32'(sched_err), 32'd1);

    // Reset asserted during the first replay cycle of a double deferral.
    step(); c = cyc;
    do_idu(REG_DE, 16'hAAAA, c);
    alu_req = REG_E; alu_data = 8'h33; alu_skip_flags = 1'b1; alu_wren = 1'b1;
    data_bus_req = REG_E; data_bus_data = 8'h44; data_bus_wren = 1'b1;
    step(); clr();
    chk("t6_stall_c1", 32'(stall), 32'd1);
    #1 reset = 1'b0;
    #1;
    chk("t6_stall_rst", 32'(stall), 32'd0);
    chk("t6_err_rst", 32'(sched_err), 32'd0);
    chk("t6_wrens_rst", 32'({rf_alu_wren, rf_idu_wren, rf_data_bus_wren}), 32'd0);
    step();
    step();
    #2 reset = 1'b1;
    idle(4);
    chk("t6_stall_after", 32'(stall), 32'd0);
    step(); c = cyc;
    do_alu(REG_A, 8'h5A, 1'b1, c);
    idle(2);

    chk("q_idu_left", 32'(q_idu.size()), 32'd0);
    chk("q_alu_left", 32'(q_alu.size()), 32'd0);
    chk("q_bus_left", 32'(q_bus.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
